// File: rtl/instr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_pkg : opcodes, format and FSM types shared by the encoder      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package instr_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_BAD} fmt_e;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_JAL:                   return FMT_J;
            OP_REG:                   return FMT_R;
            default:                  return FMT_BAD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_pack : combinational RV32I field packer with legality flag       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imm_pack
    import instr_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    fmt_e w_fmt;
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;

    assign w_fmt = fmt_of(i_opcode);

    // A value fits in N signed bits when all bits from N-1 upward agree.
    assign w_fit12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_fit13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign w_fit21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    always_comb begin
        o_word  = 32'd0;
        o_legal = 1'b0;
        case (w_fmt)
            FMT_R: begin
                o_word  = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                o_legal = 1'b1;
            end
            FMT_I: begin
                o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_legal = w_fit12;
            end
            FMT_S: begin
                o_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_legal = w_fit12;
            end
            FMT_B: begin
                o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], i_opcode};
                o_legal = w_fit13 & ~i_imm[0];
            end
            FMT_J: begin
                o_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_legal = w_fit21 & ~i_imm[0];
            end
            default: begin
                o_word  = 32'd0;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_encoder : streams packed RV32I words into instruction memory   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_last_i,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    input  logic              imem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [7:0]        err_cnt_o
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [7:0]        r_err_cnt;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_ready;
    logic              w_accept;
    logic              w_wr_done;
    logic              w_start;

    imm_pack u_imm_pack (
        .i_opcode (opcode_i),
        .i_rd     (rd_i),
        .i_rs1    (rs1_i),
        .i_rs2    (rs2_i),
        .i_funct3 (funct3_i),
        .i_funct7 (funct7_i),
        .i_imm    (imm_i),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    assign w_start   = (r_state == IDLE) && start_i;
    assign w_wr_done = r_we && imem_ready_i;
    assign w_ready   = (r_state == RUN) && (!r_we || imem_ready_i);
    assign w_accept  = in_valid_i && w_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_i) w_state_nxt = RUN;
            RUN:     if (w_accept && in_last_i) w_state_nxt = DRAIN;
            DRAIN:   if (!r_we) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A reload in the same cycle as a completed write keeps r_we high: no bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we      <= 1'b0;
            r_wdata   <= 32'd0;
            r_addr    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            if (w_accept && w_legal) begin
                r_we    <= 1'b1;
                r_wdata <= w_word;
            end else if (w_wr_done) begin
                r_we    <= 1'b0;
            end

            if (w_start) begin
                r_addr <= base_addr_i;
            end else if (w_wr_done) begin
                r_addr <= r_addr + 1'b1;
            end

            if (w_start) begin
                r_err     <= 1'b0;
                r_err_cnt <= 8'd0;
            end else if (w_accept && !w_legal) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign in_ready_o   = w_ready;
    assign imem_we_o    = r_we;
    assign imem_addr_o  = r_addr;
    assign imem_wdata_o = r_wdata;
    assign busy_o       = (r_state != IDLE);
    assign done_o       = (r_state == DONE);
    assign err_o        = r_err;
    assign err_cnt_o    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_encoder : directed vector bench for instr_encoder           |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instr_encoder;

    localparam int ADDR_W = 10;
    localparam int NV     = 19;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b1;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] base_addr_i = '0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic              in_last_i = 1'b0;
    logic [6:0]        opcode_i = '0;
    logic [4:0]        rd_i = '0;
    logic [4:0]        rs1_i = '0;
    logic [4:0]        rs2_i = '0;
    logic [2:0]        funct3_i = '0;
    logic [6:0]        funct7_i = '0;
    logic [31:0]       imm_i = '0;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;
    logic              imem_ready_i = 1'b0;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [7:0]        err_cnt_o;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_last_i    (in_last_i),
        .opcode_i     (opcode_i),
        .rd_i         (rd_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .funct3_i     (funct3_i),
        .funct7_i     (funct7_i),
        .imm_i        (imm_i),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .imem_ready_i (imem_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o)
    );

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
        bit          legal;
    } vec_t;

    vec_t vecs [NV];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input logic [31:0] word,
                                input bit legal);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.word = word; v.legal = legal;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v, input bit last);
        in_valid_i = 1'b1;
        in_last_i  = last;
        opcode_i   = v.op;
        rd_i       = v.rd;
        rs1_i      = v.rs1;
        rs2_i      = v.rs2;
        funct3_i   = v.f3;
        funct7_i   = v.f7;
        imm_i      = v.imm;
    endtask

    task automatic start_session(input logic [ADDR_W-1:0] base);
        start_i     = 1'b1;
        base_addr_i = base;
        tick();
        start_i = 1'b0;
        check("start_busy", busy_o, 1);
        check("start_err_clr", err_o, 0);
        check("start_errcnt_clr", err_cnt_o, 0);
        check("start_addr", imem_addr_o, base);
    endtask

    task automatic wait_done();
        int nd = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done_o) nd++;
            if (nd > 0 && !busy_o) break;
        end
        check("done_pulses", nd, 1);
        check("idle_busy", busy_o, 0);
        check("idle_done", done_o, 0);
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_addr;
        int                exp_err;

        //             op          rd     rs1    rs2    f3      f7         imm           word          legal
        vecs[0]  = mk(7'b0010011, 5'd1, 5'd0, 5'd9, 3'd0, 7'h55, 32'hFFFFFFFF, 32'hFFF00093, 1'b1); // addi x1,x0,-1
        vecs[1]  = mk(7'b0100011, 5'd5, 5'd1, 5'd2, 3'd2, 7'h11, 32'h00000008, 32'h0020A423, 1'b1); // sw x2,8(x1)
        vecs[2]  = mk(7'b1100011, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b1); // beq -4
        vecs[3]  = mk(7'b1101111, 5'd1, 5'd3, 5'd4, 3'd5, 7'h7F, 32'h00000800, 32'h001000EF, 1'b1); // jal x1,2048
        vecs[4]  = mk(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00012345, 32'h002081B3, 1'b1); // add x3,x1,x2
        vecs[5]  = mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h0,        1'b0); // addi 2048
        vecs[6]  = mk(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000003, 32'h0,        1'b0); // beq odd
        vecs[7]  = mk(7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 32'h0,        1'b0); // lui unsupported
        vecs[8]  = mk(7'b0010011, 5'd5, 5'd6, 5'd0, 3'd0, 7'h00, 32'h000007FF, 32'h7FF30293, 1'b1); // addi 2047
        vecs[9]  = mk(7'b0000011, 5'd5, 5'd6, 5'd0, 3'd2, 7'h00, 32'hFFFFF800, 32'h80032283, 1'b1); // lw -2048
        vecs[10] = mk(7'b0010011, 5'd5, 5'd6, 5'd0, 3'd0, 7'h00, 32'hFFFFF7FF, 32'h0,        1'b0); // addi -2049
        vecs[11] = mk(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000FFE, 32'h7E000FE3, 1'b1); // beq 4094
        vecs[12] = mk(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000, 32'h80000063, 1'b1); // beq -4096
        vecs[13] = mk(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 32'h0,        1'b0); // beq 4096
        vecs[14] = mk(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 32'h8000006F, 1'b1); // jal min
        vecs[15] = mk(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 32'h0,        1'b0); // jal over
        vecs[16] = mk(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000FFFFE, 32'h7FFFF06F, 1'b1); // jal max
        vecs[17] = mk(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0,        32'h402081B3, 1'b1); // sub
        vecs[18] = mk(7'b1100111, 5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'h0,        32'h00008067, 1'b1); // jalr ret

        #2 rst_ni = 1'b0;
        #10;
        check("rst_we", imem_we_o, 0);
        check("rst_addr", imem_addr_o, 0);
        check("rst_wdata", imem_wdata_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_errcnt", err_cnt_o, 0);
        check("rst_in_ready", in_ready_o, 0);
        @(negedge clk) rst_ni = 1'b1;
        tick();

        // Session 1: full table, back-to-back, memory always ready
        imem_ready_i = 1'b1;
        start_session(10'h010);
        exp_addr = 10'h010;
        exp_err  = 0;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i], i == NV - 1);
            check($sformatf("v%0d_in_ready", i), in_ready_o, 1);
            tick();
            if (vecs[i].legal) begin
                check($sformatf("v%0d_we", i), imem_we_o, 1);
                check($sformatf("v%0d_addr", i), imem_addr_o, exp_addr);
                check($sformatf("v%0d_wdata", i), imem_wdata_o, vecs[i].word);
                exp_addr = exp_addr + 1'b1;
            end else begin
                exp_err++;
                check($sformatf("v%0d_rej_we", i), imem_we_o, 0);
                check($sformatf("v%0d_rej_cnt", i), err_cnt_o, exp_err);
                check($sformatf("v%0d_rej_addr", i), imem_addr_o, exp_addr);
            end
            check($sformatf("v%0d_err", i), err_o, (exp_err != 0) ? 1 : 0);
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        wait_done();
        check("s1_final_addr", imem_addr_o, exp_addr);
        check("s1_err_sticky", err_o, 1);
        check("s1_errcnt_final", err_cnt_o, 6);

        // Session 2: backpressure, ignored restart, address wrap
        imem_ready_i = 1'b0;
        start_session(10'h3FF);
        drive(vecs[0], 1'b0);
        tick();
        check("bp_we", imem_we_o, 1);
        check("bp_addr0", imem_addr_o, 10'h3FF);
        drive(vecs[4], 1'b1);
        start_i     = 1'b1;
        base_addr_i = 10'h155;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_in_ready_%0d", k), in_ready_o, 0);
            tick();
            check($sformatf("bp_wdata_%0d", k), imem_wdata_o, 32'hFFF00093);
            check($sformatf("bp_addr_%0d", k), imem_addr_o, 10'h3FF);
            check($sformatf("bp_we_%0d", k), imem_we_o, 1);
        end
        start_i      = 1'b0;
        imem_ready_i = 1'b1;
        #1;
        check("bp_release_ready", in_ready_o, 1);
        tick();
        check("wrap_we", imem_we_o, 1);
        check("wrap_addr", imem_addr_o, 10'h000);
        check("wrap_wdata", imem_wdata_o, 32'h002081B3);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        wait_done();
        check("wrap_final_addr", imem_addr_o, 10'h001);

        // Session 3: reset mid-run with a pending write, then a clean restart
        imem_ready_i = 1'b0;
        start_session(10'h100);
        drive(vecs[3], 1'b0);
        tick();
        check("pend_we", imem_we_o, 1);
        in_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("abort_we", imem_we_o, 0);
        check("abort_addr", imem_addr_o, 0);
        check("abort_wdata", imem_wdata_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_in_ready", in_ready_o, 0);
        @(negedge clk) rst_ni = 1'b1;
        tick();
        imem_ready_i = 1'b1;
        start_session(10'h020);
        drive(vecs[3], 1'b0);
        tick();
        check("re_we", imem_we_o, 1);
        check("re_addr", imem_addr_o, 10'h020);
        check("re_wdata", imem_wdata_o, 32'h001000EF);
        drive(vecs[7], 1'b1);
        tick();
        check("rej_last_we", imem_we_o, 0);
        check("rej_last_cnt", err_cnt_o, 1);
        check("rej_last_err", err_o, 1);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        wait_done();
        check("re_final_addr", imem_addr_o, 10'h021);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
